// File: rtl/sm83_bus_fabric.sv
// Address-decode fabric between the SM83 memory port and N memory-mapped targets.
// Each access is decoded by base/mask, stretched by per-region wait states and closed with a registered ready pulse.
module sm83_bus_fabric #(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            ADDR_W      = 16,
    parameter int                            DATA_W      = 8,
    parameter int                            WAIT_W      = 3,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'hFF80, 16'hC000, 16'h8000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hFF80, 16'hE000, 16'hE000, 16'h8000},
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {3'd0, 3'd0, 3'd1, 3'd0},
    parameter logic [NUM_REGIONS-1:0]        REGION_RO   = 4'b0001,
    parameter logic [DATA_W-1:0]             OPEN_BUS    = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          ready,
    output logic                          err,
    output logic [NUM_REGIONS-1:0]        dev_sel,
    output logic [ADDR_W-1:0]             dev_addr,
    output logic [DATA_W-1:0]             dev_wdata,
    output logic                          dev_wen,
    input  logic [NUM_REGIONS*DATA_W-1:0] dev_rdata,
    output logic [1:0]                    dbg_state
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    // Handshake: req is a level held until ready; addr/we/wdata are sampled once in
    // IDLE, and ready (with err) pulses for exactly one cycle per accepted request.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]    r_region;
    logic                r_hit;
    logic                r_we;
    logic [ADDR_W-1:0]   r_dev_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_hit;
    logic [IDX_W-1:0]    w_region;
    logic [ADDR_W-1:0]   w_mask;
    logic [WAIT_W-1:0]   w_wait;
    logic                w_last;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_hit    = 1'b0;
        w_region = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                w_hit    = 1'b1;
                w_region = IDX_W'(i);
            end
        end
        w_mask = w_hit ? REGION_MASK[int'(w_region)*ADDR_W +: ADDR_W] : '0;
        w_wait = w_hit ? REGION_WAIT[int'(w_region)*WAIT_W +: WAIT_W] : '0;
    end

    assign w_last = (r_state == S_ACCESS) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        ready   = 1'b0;
        err     = 1'b0;
        dev_sel = '0;
        dev_wen = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (r_hit) dev_sel[r_region] = 1'b1;
                if (r_cnt == '0) begin
                    dev_wen = r_we & r_hit & ~REGION_RO[r_region];
                    w_next  = S_RESP;
                end
            end
            S_RESP: begin
                ready  = 1'b1;
                err    = ~r_hit | (r_we & REGION_RO[r_region]);
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_region   <= '0;
            r_hit      <= 1'b0;
            r_we       <= 1'b0;
            r_dev_addr <= '0;
            r_wdata    <= '0;
            r_rdata    <= OPEN_BUS;
        end else begin
            if (r_state == S_IDLE && req) begin
                r_cnt      <= w_wait;
                r_region   <= w_region;
                r_hit      <= w_hit;
                r_we       <= we;
                r_dev_addr <= addr & ~w_mask;
                r_wdata    <= wdata;
            end else if (r_state == S_ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - WAIT_W'(1);
            end
            // Targets only need valid read data at this final ACCESS edge.
            if (w_last && !r_we) begin
                r_rdata <= r_hit ? dev_rdata[int'(r_region)*DATA_W +: DATA_W] : OPEN_BUS;
            end
        end
    end

    assign rdata     = r_rdata;
    assign dev_addr  = r_dev_addr;
    assign dev_wdata = r_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sm83_bus_fabric.sv
// Bench for sm83_bus_fabric: directed test-plan accesses, a mid-access reset and random traffic
// against small target memories, with a {err, rdata} scoreboard queue popped on every ready.
module tb_sm83_bus_fabric;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        ready;
    logic        err;
    logic [3:0]  dev_sel;
    logic [15:0] dev_addr;
    logic [7:0]  dev_wdata;
    logic        dev_wen;
    logic [31:0] dev_rdata;
    logic [1:0]  dbg_state;

    sm83_bus_fabric dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .err       (err),
        .dev_sel   (dev_sel),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_wen   (dev_wen),
        .dev_rdata (dev_rdata),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory map as the bench understands it, index 0 = ROM .. 3 = HRAM.
    logic [15:0] tb_base [4] = '{16'h0000, 16'h8000, 16'hC000, 16'hFF80};
    logic [15:0] tb_mask [4] = '{16'h8000, 16'hE000, 16'hE000, 16'hFF80};
    int          tb_wait [4] = '{0, 1, 0, 0};
    bit          tb_ro   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Target memories (driven by the DUT strobes) and the bench reference copy.
    logic [7:0] tgt_mem [4][256];
    logic [7:0] ref_mem [4][256];
    logic [7:0] last_rdata = 8'hFF;

    logic [8:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    always_comb begin
        dev_rdata = '0;
        for (int i = 0; i < 4; i++) dev_rdata[i*8 +: 8] = tgt_mem[i][dev_addr[7:0]];
    end

    always @(posedge clk) begin
        if (dev_wen) begin
            for (int i = 0; i < 4; i++) if (dev_sel[i]) tgt_mem[i][dev_addr[7:0]] = dev_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tb_decode(input logic [15:0] a, output int rg, output bit hit,
                             output logic [15:0] loc, output int wt);
        rg = 0; hit = 1'b0; loc = a; wt = 0;
        for (int i = 3; i >= 0; i--) begin
            if ((a & tb_mask[i]) == tb_base[i]) begin
                rg = i; hit = 1'b1;
            end
        end
        if (hit) begin
            loc = a & ~tb_mask[rg];
            wt  = tb_wait[rg];
        end
    endtask

    // Called on a negedge; returns on the negedge where ready was seen.
    task automatic access(input bit w, input logic [15:0] a, input logic [7:0] d, input bit hold);
        int rg; bit hit; logic [15:0] loc; int wt;
        int exp_lat; int sel_n; int wen_n; int n; bit done;
        logic [7:0] exp_rd; bit exp_err; logic [8:0] exp;
        bit do_write;
        tb_decode(a, rg, hit, loc, wt);
        exp_lat  = wt + 2 + (req ? 1 : 0);
        do_write = w && hit && !tb_ro[rg];
        exp_err  = !hit || (w && tb_ro[rg]);
        if (w) exp_rd = last_rdata;
        else   exp_rd = hit ? ref_mem[rg][loc[7:0]] : 8'hFF;
        last_rdata = exp_rd;
        if (do_write) ref_mem[rg][loc[7:0]] = d;
        exp_q.push_back({exp_err, exp_rd});
        req = 1'b1; we = w; addr = a; wdata = d;
        sel_n = 0; wen_n = 0; n = 0; done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (dev_sel != 4'b0000) begin
                sel_n++;
                if (sel_n == 1) begin
                    check("dev_sel", 32'(dev_sel), hit ? 32'(1 << rg) : 32'h0);
                    check("dev_addr", 32'(dev_addr), 32'(loc));
                end
            end
            if (dev_wen) begin
                wen_n++;
                check("wen_last_sel_cycle", sel_n, wt + 1);
                check("dev_wdata", 32'(dev_wdata), 32'(d));
            end
            if (ready) begin
                check("latency", n, exp_lat);
                exp = exp_q.pop_front();
                check("resp_err_rdata", 32'({err, rdata}), 32'(exp));
                done = 1'b1;
            end
        end
        if (!done) begin
            check("ready_timeout", 0, 1);
            void'(exp_q.pop_front());
        end
        check("sel_cycles", sel_n, hit ? wt + 1 : 0);
        check("wen_cycles", wen_n, do_write ? 1 : 0);
        if (!hold) begin
            req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_sel"}, 32'(dev_sel), 0);
        check({tag, "_wen"}, 32'(dev_wen), 0);
        check({tag, "_addr"}, 32'(dev_addr), 0);
        check({tag, "_wdata"}, 32'(dev_wdata), 0);
        check({tag, "_rdata"}, 32'(rdata), 32'h00FF);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    initial begin
        logic [15:0] ra;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 256; j++) begin
                tgt_mem[i][j] = 8'($urandom_range(0, 255));
                ref_mem[i][j] = tgt_mem[i][j];
            end
        end
        tgt_mem[0][8'h50] = 8'h3C;
        ref_mem[0][8'h50] = 8'h3C;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b0, 16'h0150, 8'h00, 1'b0);
        access(1'b1, 16'hC123, 8'h5A, 1'b0);
        access(1'b0, 16'hC123, 8'h00, 1'b0);
        access(1'b0, 16'h9800, 8'h00, 1'b0);
        access(1'b1, 16'h2000, 8'hA5, 1'b0);
        access(1'b0, 16'h2000, 8'h00, 1'b0);
        access(1'b0, 16'hFE00, 8'h00, 1'b0);
        access(1'b1, 16'hFE00, 8'h77, 1'b0);
        access(1'b0, 16'hFF80, 8'h00, 1'b1);
        access(1'b1, 16'hFFFE, 8'hC3, 1'b0);
        access(1'b0, 16'hFFFE, 8'h00, 1'b0);
        access(1'b0, 16'h0150, 8'h00, 1'b0);

        // Reset in the first VRAM ACCESS cycle: everything must drop at once.
        req = 1'b1; we = 1'b0; addr = 16'h9800;
        @(negedge clk);
        check("mid_sel_before_reset", 32'(dev_sel), 32'h2);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        req = 1'b0;
        last_rdata = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("mid_reset_no_ready", 32'(ready), 0);
            check("mid_reset_no_wen", 32'(dev_wen), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b0, 16'h9800, 8'h00, 1'b0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: ra = 16'($urandom_range(16'h0000, 16'h7FFF));
                1: ra = 16'($urandom_range(16'h8000, 16'h9FFF));
                2: ra = 16'($urandom_range(16'hC000, 16'hDFFF));
                3: ra = 16'($urandom_range(16'hFF80, 16'hFFFF));
                default: ra = 16'($urandom_range(0, 65535));
            endcase
            access(1'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 255)),
                   (k != 39) && ($urandom_range(0, 1) == 1));
            if (!req) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
